// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared constants and enumerations for the RV32I main decoder:
//   - major opcode constants
//   - ALU operation, immediate format, next-PC source, write-back source
//   - ALU operand select encodings
//   - funct7 values that qualify R-type / shift-immediate encodings
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_NONE = 3'b111
    } imm_type_e;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JAL    = 3'b010,
        NPC_JALR   = 3'b011
    } next_pc_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wdata_sel_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS2 = 2'b00,
        SRC2_IMM = 2'b01
    } src2_sel_e;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Maps funct3/funct7 of an OP or OP-IMM instruction to the ALU operation and
// flags funct7 values that do not form a legal encoding.
// Ports:
//   is_rtype       in   1  high for OP (register-register), low for OP-IMM
//   funct3         in   3  instr[14:12]
//   funct7         in   7  instr[31:25]
//   alu_op         out  4  selected ALU operation
//   funct7_illegal out  1  funct7 not allowed for this funct3 / form
// ---------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       funct7_illegal
);

    logic f7_zero;
    logic f7_alt;

    assign f7_zero = (funct7 == F7_ZERO);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        alu_op         = ALU_ADD;
        funct7_illegal = 1'b0;
        case (funct3)
            3'b000: begin
                // OP-IMM has no SUBI: funct7 bits are immediate bits there.
                if (is_rtype) begin
                    if (f7_alt) begin
                        alu_op = ALU_SUB;
                    end else if (!f7_zero) begin
                        funct7_illegal = 1'b1;
                    end
                end
            end
            3'b001: begin
                alu_op = ALU_SLL;
                // Shift-immediate still encodes funct7 in the upper bits.
                if (!f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
            3'b010: begin
                alu_op = ALU_SLT;
                if (is_rtype && !f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
            3'b011: begin
                alu_op = ALU_SLTU;
                if (is_rtype && !f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
            3'b100: begin
                alu_op = ALU_XOR;
                if (is_rtype && !f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
            3'b101: begin
                alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                if (!f7_zero && !f7_alt) begin
                    funct7_illegal = 1'b1;
                end
            end
            3'b110: begin
                alu_op = ALU_OR;
                if (is_rtype && !f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
            default: begin
                alu_op = ALU_AND;
                if (is_rtype && !f7_zero) begin
                    funct7_illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/rv32i_controller.sv
// ---------------------------------------------------------------------------
// rv32i_controller
// Combinational main decoder of the single-cycle RV32I core. Decodes opcode,
// funct3, funct7 and the branch-compare flags into datapath controls and
// flags unsupported encodings as illegal. An illegal encoding forces every
// control to its idle value (no write, PC+4).
//
// Optional build macro: CTRL_ILLEGAL_LATCH_EN adds illegal_seen_o, a sticky
// flag set on clk_i when illegal_instr_o is high and cleared only by rst_i.
// Without the macro the design holds no state and clk_i is unused.
//
// Ports:
//   clk_i            in   1  core clock (sticky illegal flag only)
//   rst_i            in   1  asynchronous active-high reset
//   opcode_i         in   7  instr[6:0]
//   funct3_i         in   3  instr[14:12]
//   funct7_i         in   7  instr[31:25]
//   branch_eq_i      in   1  rs1 == rs2
//   branch_lt_i      in   1  signed rs1 < rs2
//   branch_ltu_i     in   1  unsigned rs1 < rs2
//   rf_wen_o         out  1  register-file write enable
//   rf_wdata_sel_o   out  2  write-back source (ALU, load, PC+4, imm)
//   alu_op_o         out  4  ALU operation
//   alu_src1_sel_o   out  2  ALU operand 1 (rs1, PC, zero)
//   alu_src2_sel_o   out  2  ALU operand 2 (rs2, imm)
//   mem_wen_o        out  1  data-memory write enable
//   mem_size_o       out  3  access size (funct3 for loads/stores)
//   mem_signed_o     out  1  sign-extend load data
//   imm_type_o       out  3  immediate format
//   next_pc_sel_o    out  3  next-PC source
//   illegal_instr_o  out  1  unsupported encoding
//   illegal_seen_o   out  1  sticky illegal flag (CTRL_ILLEGAL_LATCH_EN only)
// ---------------------------------------------------------------------------
module rv32i_controller
    import ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       branch_eq_i,
    input  logic       branch_lt_i,
    input  logic       branch_ltu_i,
    output logic       rf_wen_o,
    output logic [1:0] rf_wdata_sel_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] alu_src1_sel_o,
    output logic [1:0] alu_src2_sel_o,
    output logic       mem_wen_o,
    output logic [2:0] mem_size_o,
    output logic       mem_signed_o,
    output logic [2:0] imm_type_o,
    output logic [2:0] next_pc_sel_o,
    output logic       illegal_instr_o
`ifdef CTRL_ILLEGAL_LATCH_EN
    ,
    output logic       illegal_seen_o
`endif
);

    logic    is_rtype;
    alu_op_e dec_alu_op;
    logic    dec_f7_illegal;
    logic    taken;

    assign is_rtype = (opcode_i == OPC_OP);

    alu_decoder u_alu_decoder (
        .is_rtype       (is_rtype),
        .funct3         (funct3_i),
        .funct7         (funct7_i),
        .alu_op         (dec_alu_op),
        .funct7_illegal (dec_f7_illegal)
    );

    always_comb begin
        rf_wen_o        = 1'b0;
        rf_wdata_sel_o  = WB_ALU;
        alu_op_o        = ALU_ADD;
        alu_src1_sel_o  = SRC1_RS1;
        alu_src2_sel_o  = SRC2_RS2;
        mem_wen_o       = 1'b0;
        mem_size_o      = 3'b000;
        mem_signed_o    = 1'b0;
        imm_type_o      = IMM_NONE;
        next_pc_sel_o   = NPC_PLUS4;
        illegal_instr_o = 1'b0;
        taken           = 1'b0;

        case (opcode_i)
            OPC_OP: begin
                rf_wen_o        = 1'b1;
                alu_op_o        = dec_alu_op;
                illegal_instr_o = dec_f7_illegal;
            end
            OPC_OP_IMM: begin
                rf_wen_o        = 1'b1;
                alu_op_o        = dec_alu_op;
                alu_src2_sel_o  = SRC2_IMM;
                imm_type_o      = IMM_I;
                illegal_instr_o = dec_f7_illegal;
            end
            OPC_LOAD: begin
                rf_wen_o        = 1'b1;
                rf_wdata_sel_o  = WB_LOAD;
                alu_src2_sel_o  = SRC2_IMM;
                imm_type_o      = IMM_I;
                mem_size_o      = funct3_i;
                mem_signed_o    = ~funct3_i[2];
                // Legal: LB, LH, LW, LBU, LHU.
                illegal_instr_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
            end
            OPC_STORE: begin
                mem_wen_o       = 1'b1;
                alu_src2_sel_o  = SRC2_IMM;
                imm_type_o      = IMM_S;
                mem_size_o      = funct3_i;
                illegal_instr_o = (funct3_i > 3'b010);
            end
            OPC_BRANCH: begin
                imm_type_o = IMM_B;
                // funct3[0] inverts the base condition selected by funct3[2:1].
                case (funct3_i[2:1])
                    2'b00:   taken = branch_eq_i ^ funct3_i[0];
                    2'b10:   taken = branch_lt_i ^ funct3_i[0];
                    2'b11:   taken = branch_ltu_i ^ funct3_i[0];
                    default: illegal_instr_o = 1'b1;
                endcase
                next_pc_sel_o = taken ? NPC_BRANCH : NPC_PLUS4;
            end
            OPC_JAL: begin
                rf_wen_o       = 1'b1;
                rf_wdata_sel_o = WB_PC4;
                imm_type_o     = IMM_J;
                next_pc_sel_o  = NPC_JAL;
            end
            OPC_JALR: begin
                rf_wen_o        = 1'b1;
                rf_wdata_sel_o  = WB_PC4;
                imm_type_o      = IMM_I;
                next_pc_sel_o   = NPC_JALR;
                illegal_instr_o = (funct3_i != 3'b000);
            end
            OPC_LUI: begin
                rf_wen_o       = 1'b1;
                rf_wdata_sel_o = WB_IMM;
                imm_type_o     = IMM_U;
            end
            OPC_AUIPC: begin
                rf_wen_o       = 1'b1;
                alu_src1_sel_o = SRC1_PC;
                alu_src2_sel_o = SRC2_IMM;
                imm_type_o     = IMM_U;
            end
            OPC_FENCE: begin
                // Single-cycle core with one memory port: FENCE is a NOP.
            end
            default: begin
                illegal_instr_o = 1'b1;
            end
        endcase

        if (illegal_instr_o) begin
            rf_wen_o       = 1'b0;
            rf_wdata_sel_o = WB_ALU;
            alu_op_o       = ALU_ADD;
            alu_src1_sel_o = SRC1_RS1;
            alu_src2_sel_o = SRC2_RS2;
            mem_wen_o      = 1'b0;
            mem_size_o     = 3'b000;
            mem_signed_o   = 1'b0;
            imm_type_o     = IMM_NONE;
            next_pc_sel_o  = NPC_PLUS4;
        end

        // Reset only blocks state-changing controls; selects keep decoding.
        if (rst_i) begin
            rf_wen_o        = 1'b0;
            mem_wen_o       = 1'b0;
            next_pc_sel_o   = NPC_PLUS4;
            illegal_instr_o = 1'b0;
        end
    end

`ifdef CTRL_ILLEGAL_LATCH_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_seen_o <= 1'b0;
        end else if (illegal_instr_o) begin
            illegal_seen_o <= 1'b1;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk_i;
`endif

endmodule

// File: tb/tb_rv32i_controller.sv
module tb_rv32i_controller;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_i;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       branch_eq, branch_lt, branch_ltu;
  logic       rf_wen;
  logic [1:0] rf_wdata_sel;
  logic [3:0] alu_op;
  logic [1:0] alu_src1_sel, alu_src2_sel;
  logic       mem_wen;
  logic [2:0] mem_size;
  logic       mem_signed;
  logic [2:0] imm_type;
  logic [2:0] next_pc_sel;
  logic       illegal_instr;
`ifdef CTRL_ILLEGAL_LATCH_EN
  logic       illegal_seen;
`endif

  always #5 clk = ~clk;

  rv32i_controller dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .opcode_i        (opcode),
    .funct3_i        (funct3),
    .funct7_i        (funct7),
    .branch_eq_i     (branch_eq),
    .branch_lt_i     (branch_lt),
    .branch_ltu_i    (branch_ltu),
    .rf_wen_o        (rf_wen),
    .rf_wdata_sel_o  (rf_wdata_sel),
    .alu_op_o        (alu_op),
    .alu_src1_sel_o  (alu_src1_sel),
    .alu_src2_sel_o  (alu_src2_sel),
    .mem_wen_o       (mem_wen),
    .mem_size_o      (mem_size),
    .mem_signed_o    (mem_signed),
    .imm_type_o      (imm_type),
    .next_pc_sel_o   (next_pc_sel),
    .illegal_instr_o (illegal_instr)
`ifdef CTRL_ILLEGAL_LATCH_EN
    ,
    .illegal_seen_o  (illegal_seen)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       rf_wen;
    logic [1:0] wsel;
    logic [3:0] alu;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       mem_wen;
    logic [2:0] msize;
    logic       msigned;
    logic [2:0] imm;
    logic [2:0] npc;
    logic       ill;
  } ctrl_t;

  localparam ctrl_t IDLE = '{rf_wen: 1'b0, wsel: 2'd0, alu: 4'd0, s1: 2'd0, s2: 2'd0,
                             mem_wen: 1'b0, msize: 3'd0, msigned: 1'b0, imm: 3'd7,
                             npc: 3'd0, ill: 1'b0};

  // Instruction-level rules: each opcode class sets its controls, then
  // illegality wipes everything back to idle, then reset masks enables.
  function automatic ctrl_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic eq, input logic lt,
                                  input logic ltu, input logic rst);
    ctrl_t c;
    logic bad;
    logic [3:0] tab [8];
    logic cond [8];
    tab  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    cond = '{eq, !eq, 1'b0, 1'b0, lt, !lt, ltu, !ltu};
    c = IDLE;
    bad = 1'b0;
    case (op)
      7'b0110011: begin
        c.rf_wen = 1'b1;
        c.alu = tab[f3];
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) c.alu = tab[f3] + 4'd1;
        else if (f7 != 7'h00) bad = 1'b1;
      end
      7'b0010011: begin
        c.rf_wen = 1'b1; c.s2 = 2'd1; c.imm = 3'd0;
        c.alu = tab[f3];
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) c.alu = 4'd7;
          else if (f7 != 7'h00) bad = 1'b1;
        end
      end
      7'b0000011: begin
        c.rf_wen = 1'b1; c.wsel = 2'd1; c.s2 = 2'd1; c.imm = 3'd0;
        c.msize = f3; c.msigned = (f3 < 3'd4);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
      end
      7'b0100011: begin
        c.mem_wen = 1'b1; c.s2 = 2'd1; c.imm = 3'd1; c.msize = f3;
        if (f3 > 3'd2) bad = 1'b1;
      end
      7'b1100011: begin
        c.imm = 3'd2;
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
        c.npc = cond[f3] ? 3'd1 : 3'd0;
      end
      7'b1101111: begin c.rf_wen = 1'b1; c.wsel = 2'd2; c.imm = 3'd4; c.npc = 3'd2; end
      7'b1100111: begin
        c.rf_wen = 1'b1; c.wsel = 2'd2; c.imm = 3'd0; c.npc = 3'd3;
        if (f3 != 3'd0) bad = 1'b1;
      end
      7'b0110111: begin c.rf_wen = 1'b1; c.wsel = 2'd3; c.imm = 3'd3; end
      7'b0010111: begin c.rf_wen = 1'b1; c.s1 = 2'd1; c.s2 = 2'd1; c.imm = 3'd3; end
      7'b0001111: ;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = IDLE;
      c.ill = 1'b1;
    end
    if (rst) begin
      c.rf_wen = 1'b0; c.mem_wen = 1'b0; c.npc = 3'd0; c.ill = 1'b0;
    end
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  bit checking = 1'b0;
  bit done = 1'b0;

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    exp_q.push_back(exp);
    total++;
    if (act !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

`ifdef CTRL_ILLEGAL_LATCH_EN
  logic seen_m;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) seen_m <= 1'b0;
    else if (model(opcode, funct3, funct7, branch_eq, branch_lt, branch_ltu, 1'b0).ill)
      seen_m <= 1'b1;
  end
`endif

  // Per-cycle comparison of all decoded controls, away from the clock edge.
  always @(negedge clk) begin
    ctrl_t e, a;
    if (checking && !done) begin
      e = model(opcode, funct3, funct7, branch_eq, branch_lt, branch_ltu, rst_i);
      a = '{rf_wen, rf_wdata_sel, alu_op, alu_src1_sel, alu_src2_sel, mem_wen,
            mem_size, mem_signed, imm_type, next_pc_sel, illegal_instr};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctrl op=%b f3=%b f7=%b fl=%b%b%b rst=%b: got %h want %h",
                 opcode, funct3, funct7, branch_ltu, branch_lt, branch_eq, rst_i, a, e);
      end
`ifdef CTRL_ILLEGAL_LATCH_EN
      total++;
      if (illegal_seen !== seen_m) begin
        bad++;
        $display("FAIL seen: got %b want %b", illegal_seen, seen_m);
      end
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [2:0] fl);
    @(posedge clk);
    #1;
    opcode = op; funct3 = f3; funct7 = f7;
    branch_eq = fl[0]; branch_lt = fl[1]; branch_ltu = fl[2];
    #3;
  endtask

  logic [6:0] ops [13];
  logic [6:0] f7s [4];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111,
            7'b0000000};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h7f};
    rst_i = 1'b1;
    opcode = 7'b1101111; funct3 = 3'd0; funct7 = 7'd0;
    branch_eq = 1'b0; branch_lt = 1'b0; branch_ltu = 1'b0;
    #2;
    // Reset masks the enables even for a JAL, but write-back select still decodes.
    lit("rst_rf_wen", {7'd0, rf_wen}, 8'd0);
    lit("rst_npc", {5'd0, next_pc_sel}, 8'd0);
    lit("rst_wsel", {6'd0, rf_wdata_sel}, 8'd2);
`ifdef CTRL_ILLEGAL_LATCH_EN
    lit("rst_seen", {7'd0, illegal_seen}, 8'd0);
`endif
    checking = 1'b1;
    apply(7'b1111111, 3'd0, 7'd0, 3'd0);
    lit("rst_illegal", {7'd0, illegal_instr}, 8'd0);
    @(posedge clk); #1; rst_i = 1'b0;

    // Directed vectors from the plan, with hand-computed expectations.
    apply(7'b0110011, 3'd0, 7'h00, 3'd0);
    lit("add_wen", {7'd0, rf_wen}, 8'd1);
    lit("add_op", {4'd0, alu_op}, 8'h0);
    apply(7'b0110011, 3'd0, 7'h20, 3'd0);
    lit("sub_op", {4'd0, alu_op}, 8'h1);
    apply(7'b0010011, 3'd4, 7'h20, 3'd0);
    lit("xori_op", {4'd0, alu_op}, 8'h5);
    lit("xori_ill", {7'd0, illegal_instr}, 8'd0);
    apply(7'b0000011, 3'd2, 7'h00, 3'd0);
    lit("lw_wen", {6'd0, mem_wen, rf_wen}, 8'd1);
    lit("lw_size", {5'd0, mem_size}, 8'd2);
    lit("lw_wsel", {6'd0, rf_wdata_sel}, 8'd1);
    apply(7'b0100011, 3'd2, 7'h00, 3'd0);
    lit("sw_wen", {6'd0, mem_wen, rf_wen}, 8'd2);
    lit("sw_size", {5'd0, mem_size}, 8'd2);
    apply(7'b1100011, 3'd0, 7'h00, 3'b001);
    lit("beq_t", {5'd0, next_pc_sel}, 8'd1);
    apply(7'b1100011, 3'd0, 7'h00, 3'b000);
    lit("beq_nt", {5'd0, next_pc_sel}, 8'd0);
    apply(7'b1100011, 3'd7, 7'h00, 3'b000);
    lit("bgeu_t", {5'd0, next_pc_sel}, 8'd1);
    apply(7'b1101111, 3'd0, 7'h00, 3'd0);
    lit("jal_npc", {5'd0, next_pc_sel}, 8'd2);
    lit("jal_wen", {7'd0, rf_wen}, 8'd1);
    lit("jal_wsel", {6'd0, rf_wdata_sel}, 8'd2);
    apply(7'b1111111, 3'd0, 7'h00, 3'd0);
    lit("bad_ill", {7'd0, illegal_instr}, 8'd1);
    lit("bad_wen", {6'd0, mem_wen, rf_wen}, 8'd0);
`ifdef CTRL_ILLEGAL_LATCH_EN
    @(posedge clk); #1;
    lit("seen_set", {7'd0, illegal_seen}, 8'd1);
`endif
    rst_i = 1'b1;
    #1;
    lit("rst_ill", {7'd0, illegal_instr}, 8'd0);
    lit("rst_wen", {6'd0, mem_wen, rf_wen}, 8'd0);
`ifdef CTRL_ILLEGAL_LATCH_EN
    lit("seen_clr", {7'd0, illegal_seen}, 8'd0);
`endif
    // A few vectors while reset is held, then release.
    apply(7'b0100011, 3'd1, 7'h00, 3'd0);
    apply(7'b1100011, 3'd1, 7'h00, 3'd0);
    apply(7'b0110011, 3'd0, 7'h01, 3'd0);
    @(posedge clk); #1; rst_i = 1'b0;

    // Sweep of opcode classes x funct3 x funct7 x branch flags.
    for (int o = 0; o < 13; o++)
      for (int f = 0; f < 8; f++)
        for (int s = 0; s < 4; s++)
          for (int b = 0; b < 8; b++)
            apply(ops[o], f[2:0], f7s[s], b[2:0]);

    @(posedge clk); #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
